decode_issue_stage: RTL
=======================

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter DATA_W, default 32: register-file and operand data width.
REQ-002 Parameter NUM_FWD, default 2: number of downstream stages checked for RAW hazards (EXE, MEM).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 instr_in  input  32  ARM-format instruction from fetch.
REQ-006 instr_valid  input  1  instr_in is valid this cycle.
REQ-007 instr_ready  output  1  stage accepts instr_in; low means fetch holds.
REQ-008 flush  input  1  branch taken downstream; discard current instruction.
REQ-009 sr  input  4  status flags NZCV for condition check.
REQ-010 wb_en_in / wb_dest / wb_result  input  1 / 4 / DATA_W  register write-back port.
REQ-011 haz_wb_en / haz_dest  input  NUM_FWD / 4*NUM_FWD  per-stage write enable and packed destination (stage k at bits [4k+3:4k]).
REQ-012 Registered outputs: out_valid 1, wb_en 1, mem_r_en 1, mem_w_en 1, b 1, s 1, exe_cmd 4, val_rn DATA_W, val_rm DATA_W, imm 1, shift_operand 12, signed_imm_24 24, dest 4.
REQ-013 hazard  output  1  combinational RAW-hazard indication.
REQ-014 stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-015 Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_operand[11:0], signed_imm_24[23:0], imm = instr[25].
REQ-016 Control decode (exe_cmd, s, b, mem_r_en, mem_w_en, wb_en) uses the team's existing ControlUnit table; condition pass uses the existing ConditionCheck encoding on sr.
REQ-017 src1 = Rn; src2 = Rd when decoded mem_w_en = 1, else instr[3:0]; two_src = ~I | decoded mem_w_en.
REQ-018 hazard = instr_valid & ~flush & OR over k of (haz_wb_en[k] & (haz_dest[k]==src1 | (two_src & haz_dest[k]==src2))).
REQ-019 instr_ready = ~hazard | flush.
REQ-020 Register file: 16 x DATA_W; write of wb_result to wb_dest on rising edge when wb_en_in = 1; two combinational read ports addressed by src1/src2.
REQ-021 Pipeline register update priority per edge: reset > flush > hazard > instr_valid > idle.
REQ-022 Flush: out_valid and all control outputs load 0; instruction dropped.
REQ-023 Hazard: bubble inserted (out_valid = 0, controls 0); data outputs hold their previous values; fetch must hold instr_in.
REQ-024 Accept (instr_valid, no hazard, no flush): all outputs load the decoded values, out_valid = 1; when the condition fails, control outputs load 0 but out_valid = 1.
REQ-025 Idle (instr_valid = 0): out_valid and control outputs load 0.
REQ-026 Latency: instruction accepted at edge N appears on the outputs after edge N.
REQ-027 stall_cnt increments by 1 on each edge where hazard = 1, and saturates at 16'hFFFF.

Reset
REQ-028 rst = 0 at a rising edge: all registered outputs, stall_cnt and all 16 registers clear to 0; this takes priority over in-flight write-back, flush and hazard.
REQ-029 During reset, instr_ready still follows REQ-019 combinationally.

Configuration
REQ-030 Macro DECODE_WB_BYPASS_EN defined: a read port whose address equals wb_dest while wb_en_in = 1 returns wb_result in the same cycle (write-through); hazard ignores nothing extra.
REQ-031 Macro undefined: a read returns the pre-write register value; the written value is visible from the next cycle.

Verification
REQ-032 Reset, then ADD R1,R2,R3 (cond AL) valid with no hazards -> next cycle out_valid = 1, dest = 1, wb_en = 1, exe_cmd per ADD, stall_cnt = 0.
REQ-033 haz_wb_en[0] = 1, haz_dest[0] = 2, instr ADD R1,R2,R3 -> hazard = 1, instr_ready = 0, next out_valid = 0, stall_cnt = 1; clear the hazard -> accepted next edge.
REQ-034 STR R5,[R2] with haz_dest[1] = 5 and haz_wb_en[1] = 1 -> hazard = 1 (src2 = Rd); the same with an immediate-operand MOV R5 whose Rm field = 5 -> hazard = 0.
REQ-035 Instruction with cond EQ, sr Z = 0 -> out_valid = 1, wb_en = mem_w_en = mem_r_en = b = s = 0, exe_cmd = 0.
REQ-036 flush = 1 with a hazard present -> instr_ready = 1, hazard = 0, next out_valid = 0, stall_cnt unchanged.
REQ-037 Write 0x1234 to R2 while reading R2: with DECODE_WB_BYPASS_EN, val_rn latches 0x1234; without it, val_rn latches the old value 0.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: ARM-style control decode, 16-entry register file, RAW hazard stall.
// Optional same-cycle write-through on the register read ports: DECODE_WB_BYPASS_EN.
module decode_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_in,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 flush,
  input  logic [3:0]           sr,
  input  logic                 wb_en_in,
  input  logic [3:0]           wb_dest,
  input  logic [DATA_W-1:0]    wb_result,
  input  logic [NUM_FWD-1:0]   haz_wb_en,
  input  logic [4*NUM_FWD-1:0] haz_dest,
  output logic                 out_valid,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 b,
  output logic                 s,
  output logic [3:0]           exe_cmd,
  output logic [DATA_W-1:0]    val_rn,
  output logic [DATA_W-1:0]    val_rm,
  output logic                 imm,
  output logic [11:0]          shift_operand,
  output logic [23:0]          signed_imm_24,
  output logic [3:0]           dest,
  output logic                 hazard,
  output logic [15:0]          stall_cnt
);

  logic [3:0]        cond, opcode, src1, src2;
  logic [1:0]        mode;
  logic              s_bit, two_src, cond_pass, haz_hit;
  logic [3:0]        dec_exe;
  logic              dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] rd_rn, rd_rm;

  assign cond   = instr_in[31:28];
  assign mode   = instr_in[27:26];
  assign opcode = instr_in[24:21];
  assign s_bit  = instr_in[20];

  always_comb begin
    dec_exe = 4'b0000;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    case (mode)
      2'b00: begin
        dec_s = s_bit;
        case (opcode)
          4'b1101: begin dec_exe = 4'b0001; dec_wb = 1'b1; end // MOV
          4'b1111: begin dec_exe = 4'b1001; dec_wb = 1'b1; end // MVN
          4'b0100: begin dec_exe = 4'b0010; dec_wb = 1'b1; end // ADD
          4'b0101: begin dec_exe = 4'b0011; dec_wb = 1'b1; end // ADC
          4'b0010: begin dec_exe = 4'b0100; dec_wb = 1'b1; end // SUB
          4'b0110: begin dec_exe = 4'b0101; dec_wb = 1'b1; end // SBC
          4'b0000: begin dec_exe = 4'b0110; dec_wb = 1'b1; end // AND
          4'b1100: begin dec_exe = 4'b0111; dec_wb = 1'b1; end // ORR
          4'b0001: begin dec_exe = 4'b1000; dec_wb = 1'b1; end // EOR
          4'b1010: dec_exe = 4'b0100;                          // CMP
          4'b1000: dec_exe = 4'b0110;                          // TST
          default: dec_exe = 4'b0000;
        endcase
      end
      2'b01: begin
        dec_exe = 4'b0010;
        dec_s   = s_bit;
        if (s_bit) begin
          dec_mr = 1'b1;
          dec_wb = 1'b1;
        end else begin
          dec_mw = 1'b1;
        end
      end
      2'b10:   dec_b = 1'b1;
      default: dec_b = 1'b0;
    endcase
  end

  // sr = {N, Z, C, V}
  always_comb begin
    case (cond)
      4'b0000: cond_pass = sr[2];
      4'b0001: cond_pass = ~sr[2];
      4'b0010: cond_pass = sr[1];
      4'b0011: cond_pass = ~sr[1];
      4'b0100: cond_pass = sr[3];
      4'b0101: cond_pass = ~sr[3];
      4'b0110: cond_pass = sr[0];
      4'b0111: cond_pass = ~sr[0];
      4'b1000: cond_pass = sr[1] & ~sr[2];
      4'b1001: cond_pass = ~sr[1] | sr[2];
      4'b1010: cond_pass = (sr[3] == sr[0]);
      4'b1011: cond_pass = (sr[3] != sr[0]);
      4'b1100: cond_pass = ~sr[2] & (sr[3] == sr[0]);
      4'b1101: cond_pass = sr[2] | (sr[3] != sr[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Stores read Rd as the data operand, so it takes the second read port.
  assign src1    = instr_in[19:16];
  assign src2    = dec_mw ? instr_in[15:12] : instr_in[3:0];
  assign two_src = ~instr_in[25] | dec_mw;

  always_comb begin
    haz_hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (haz_wb_en[k] && ((haz_dest[4*k +: 4] == src1) ||
                           (two_src && (haz_dest[4*k +: 4] == src2))))
        haz_hit = 1'b1;
    end
  end

  assign hazard      = instr_valid & ~flush & haz_hit;
  assign instr_ready = ~hazard | flush;

`ifdef DECODE_WB_BYPASS_EN
  assign rd_rn = (wb_en_in && (wb_dest == src1)) ? wb_result : regs[src1];
  assign rd_rm = (wb_en_in && (wb_dest == src2)) ? wb_result : regs[src2];
`else
  assign rd_rn = regs[src1];
  assign rd_rm = regs[src2];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en_in) begin
      regs[wb_dest] <= wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      wb_en         <= 1'b0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      exe_cmd       <= 4'b0000;
      val_rn        <= '0;
      val_rm        <= '0;
      imm           <= 1'b0;
      shift_operand <= 12'h000;
      signed_imm_24 <= 24'h000000;
      dest          <= 4'h0;
      stall_cnt     <= 16'h0000;
    end else begin
      // Flush, bubble and idle all clear controls; data outputs hold.
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      b         <= 1'b0;
      s         <= 1'b0;
      exe_cmd   <= 4'b0000;
      if (!flush && !hazard && instr_valid) begin
        out_valid     <= 1'b1;
        val_rn        <= rd_rn;
        val_rm        <= rd_rm;
        imm           <= instr_in[25];
        shift_operand <= instr_in[11:0];
        signed_imm_24 <= instr_in[23:0];
        dest          <= instr_in[15:12];
        if (cond_pass) begin
          wb_en    <= dec_wb;
          mem_r_en <= dec_mr;
          mem_w_en <= dec_mw;
          b        <= dec_b;
          s        <= dec_s;
          exe_cmd  <= dec_exe;
        end
      end
      if (hazard && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'h0001;
    end
  end

endmodule
